// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage controller between the EX/MEM register and the
// data cache port. Issues one load/store per EX/MEM instruction, builds byte
// enables and lane-shifted store data, aligns/extends load data, stalls the
// front of the pipe until the cache answers, and parks the finished result
// while downstream is frozen so the access is never repeated.
//
// Handshake: a request (dmem_read/dmem_write with address, data, mbe) is held
// stable from issue until the one-cycle dmem_resp pulse; the response may
// arrive in the issue cycle. pipe_advance is the EX/MEM->MEM/WB transfer
// strobe sampled at the same edge.
//
// Optional feature: define MEM_STALL_PERF_EN to add the saturating
// perf_mem_ops / perf_stall_cycles counters.
// The FSM state is exported on dbg_state (0=IDLE, 1=BUSY, 2=DONE).
module mem_stage_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exmem_valid,
    input  logic              exmem_mem_read,
    input  logic              exmem_mem_write,
    input  logic [2:0]        exmem_funct3,
    input  logic [ADDR_W-1:0] exmem_alu_out,
    input  logic [DATA_W-1:0] exmem_rs2_out,
    input  logic              pipe_advance,
    input  logic              dmem_resp,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [ADDR_W-1:0] dmem_address,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_mbe,
    output logic              mem_stall,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_misalign,
`ifdef MEM_STALL_PERF_EN
    output logic [31:0]       perf_mem_ops,
    output logic [31:0]       perf_stall_cycles,
`endif
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] held_q, held_d;

    logic              is_access;
    logic              misalign_raw;
    logic              op;
    logic              req;
    logic              resp_take;
    logic              is_store;
    logic [DATA_W-1:0] aligned;
    logic [3:0]        lane_mbe;
    logic [DATA_W-1:0] lane_wdata;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;

    // Decode the access: legality, request qualification, load alignment and store lanes.
    always_comb begin
        is_access    = exmem_valid & (exmem_mem_read | exmem_mem_write);
        // Invalid size codes are folded into misalignment so they are never issued.
        misalign_raw = (exmem_funct3 == 3'b011) | (exmem_funct3 == 3'b110) |
                       (exmem_funct3 == 3'b111) |
                       ((exmem_funct3[1:0] == 2'b01) & exmem_alu_out[0]) |
                       ((exmem_funct3[1:0] == 2'b10) & (exmem_alu_out[1:0] != 2'b00));
        op           = rst & is_access & ~misalign_raw;
        req          = op & (state_q != ST_DONE);
        resp_take    = req & dmem_resp;
        // A store wins when both read and write are flagged.
        is_store     = exmem_mem_write;

        sel_byte = dmem_rdata[7:0];
        case (exmem_alu_out[1:0])
            2'b00:   sel_byte = dmem_rdata[7:0];
            2'b01:   sel_byte = dmem_rdata[15:8];
            2'b10:   sel_byte = dmem_rdata[23:16];
            default: sel_byte = dmem_rdata[31:24];
        endcase
        sel_half = exmem_alu_out[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

        aligned = dmem_rdata;
        case (exmem_funct3)
            3'b000:  aligned = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  aligned = {24'b0, sel_byte};
            3'b001:  aligned = {{16{sel_half[15]}}, sel_half};
            3'b101:  aligned = {16'b0, sel_half};
            default: aligned = dmem_rdata;
        endcase

        lane_mbe   = 4'b1111;
        lane_wdata = exmem_rs2_out;
        case (exmem_funct3[1:0])
            2'b00: begin
                lane_mbe   = 4'b0001 << exmem_alu_out[1:0];
                lane_wdata = {4{exmem_rs2_out[7:0]}};
            end
            2'b01: begin
                lane_mbe   = 4'b0011 << exmem_alu_out[1:0];
                lane_wdata = {2{exmem_rs2_out[15:0]}};
            end
            default: begin
                lane_mbe   = 4'b1111;
                lane_wdata = exmem_rs2_out;
            end
        endcase
    end

    // Drive the cache port and pipeline-facing outputs; everything reads 0 while in reset.
    always_comb begin
        dmem_read    = req & ~is_store;
        dmem_write   = req & is_store;
        dmem_address = req ? {exmem_alu_out[ADDR_W-1:2], 2'b00} : '0;
        dmem_wdata   = (req & is_store) ? lane_wdata : '0;
        dmem_mbe     = req ? (is_store ? lane_mbe : 4'b1111) : 4'b0000;
        mem_stall    = op & (state_q != ST_DONE) & ~dmem_resp;
        mem_misalign = rst & is_access & misalign_raw;
        if (!rst || mem_misalign) begin
            mem_rdata = '0;
        end else if (state_q == ST_DONE) begin
            mem_rdata = held_q;
        end else begin
            mem_rdata = aligned;
        end
        dbg_state = state_q;
    end

    // Next-state logic: wait for the response, then park the result if downstream is frozen.
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        case (state_q)
            ST_IDLE: begin
                if (op) begin
                    if (dmem_resp) begin
                        held_d  = aligned;
                        state_d = pipe_advance ? ST_IDLE : ST_DONE;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (dmem_resp) begin
                    held_d  = aligned;
                    state_d = pipe_advance ? ST_IDLE : ST_DONE;
                end
            end
            ST_DONE: begin
                if (pipe_advance) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and held-result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
        end
    end

`ifdef MEM_STALL_PERF_EN
    logic [31:0] ops_q, ops_d, stl_q, stl_d;

    // Saturating counters for completed accesses and stalled cycles.
    always_comb begin
        ops_d = ops_q;
        stl_d = stl_q;
        if (resp_take && ops_q != 32'hFFFF_FFFF) ops_d = ops_q + 32'd1;
        if (mem_stall && stl_q != 32'hFFFF_FFFF) stl_d = stl_q + 32'd1;
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ops_q <= '0;
            stl_q <= '0;
        end else begin
            ops_q <= ops_d;
            stl_q <= stl_d;
        end
    end

    assign perf_mem_ops      = ops_q;
    assign perf_stall_cycles = stl_q;
`else
    logic unused_resp_take;
    assign unused_resp_take = resp_take;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Testbench for mem_stage_ctrl: single-cycle vector table plus hand-written
// miss, downstream-hold and reset-during-miss sequences.
`timescale 1ns/1ps
module tb_mem_stage_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        exmem_valid, exmem_mem_read, exmem_mem_write;
  logic [2:0]  exmem_funct3;
  logic [31:0] exmem_alu_out, exmem_rs2_out;
  logic        pipe_advance, dmem_resp;
  logic [31:0] dmem_rdata;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_address, dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic        mem_stall;
  logic [31:0] mem_rdata;
  logic        mem_misalign;
  logic [1:0]  dbg_state;
`ifdef MEM_STALL_PERF_EN
  logic [31:0] perf_mem_ops, perf_stall_cycles;
`endif

  mem_stage_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .exmem_valid     (exmem_valid),
    .exmem_mem_read  (exmem_mem_read),
    .exmem_mem_write (exmem_mem_write),
    .exmem_funct3    (exmem_funct3),
    .exmem_alu_out   (exmem_alu_out),
    .exmem_rs2_out   (exmem_rs2_out),
    .pipe_advance    (pipe_advance),
    .dmem_resp       (dmem_resp),
    .dmem_rdata      (dmem_rdata),
    .dmem_read       (dmem_read),
    .dmem_write      (dmem_write),
    .dmem_address    (dmem_address),
    .dmem_wdata      (dmem_wdata),
    .dmem_mbe        (dmem_mbe),
    .mem_stall       (mem_stall),
    .mem_rdata       (mem_rdata),
    .mem_misalign    (mem_misalign),
`ifdef MEM_STALL_PERF_EN
    .perf_mem_ops      (perf_mem_ops),
    .perf_stall_cycles (perf_stall_cycles),
`endif
    .dbg_state       (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input string name);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty, got %h", name, mem_rdata);
    end else begin
      e = exp_q.pop_front();
      chk(name, mem_rdata, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rs2);
    exmem_valid     = 1'b1;
    exmem_mem_read  = rd;
    exmem_mem_write = wr;
    exmem_funct3    = f3;
    exmem_alu_out   = addr;
    exmem_rs2_out   = rs2;
  endtask

  task automatic drive_idle();
    exmem_valid     = 1'b0;
    exmem_mem_read  = 1'b0;
    exmem_mem_write = 1'b0;
    exmem_funct3    = 3'b010;
    exmem_alu_out   = 32'h0;
    exmem_rs2_out   = 32'h0;
    dmem_resp       = 1'b0;
    pipe_advance    = 1'b1;
    dmem_rdata      = 32'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    logic        e_read;
    logic        e_write;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_mbe;
    logic        e_mis;
    logic        e_stall;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vec_t v;

    // LW hit, LBU/LB sign cases, LHU/LH, positive LB
    vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h5555_5555, 32'hDEAD_BEEF,
                     1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 1'b0, 1'b0, 32'hDEAD_BEEF});
    vecs.push_back('{1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'h0, 32'h80FF_0000,
                     1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0000_0080});
    vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0, 32'h80FF_0000,
                     1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF, 1'b0, 1'b0, 32'hFFFF_FF80});
    vecs.push_back('{1'b1, 1'b0, 3'b101, 32'h0000_0012, 32'h0, 32'h8001_1234,
                     1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0000_8001});
    vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h0000_0012, 32'h0, 32'h8001_1234,
                     1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b0, 1'b0, 32'hFFFF_8001});
    vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h0000_0201, 32'h0, 32'h0000_7F00,
                     1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0000_007F});
    // Stores: SH upper, SB lane 1, SW, read+write treated as SB, SH lower
    vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h0000_0402, 32'h1234_ABCD, 32'h0,
                     1'b0, 1'b1, 32'h0000_0400, 32'hABCD_ABCD, 4'hC, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h0000_0401, 32'h0000_00A5, 32'h0,
                     1'b0, 1'b1, 32'h0000_0400, 32'hA5A5_A5A5, 4'h2, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h0000_0404, 32'hCAFE_F00D, 32'h0,
                     1'b0, 1'b1, 32'h0000_0404, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 3'b000, 32'h0000_0403, 32'h0000_0011, 32'h0,
                     1'b0, 1'b1, 32'h0000_0400, 32'h1111_1111, 4'h8, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h0000_0400, 32'h0000_BEEF, 32'h0,
                     1'b0, 1'b1, 32'h0000_0400, 32'hBEEF_BEEF, 4'h3, 1'b0, 1'b0, 32'h0});
    // Misaligned / illegal size: nothing issued, result forced to 0
    vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'hDEAD_BEEF,
                     1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h0000_0011, 32'h0, 32'hDEAD_BEEF,
                     1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF,
                     1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h0000_0406, 32'h1234_5678, 32'h0,
                     1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0});
    // Live instruction without memory access
    vecs.push_back('{1'b0, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h1234_5678,
                     1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h1234_5678});

    // ---- reset: outputs forced to 0 even with an access present ----
    rst = 1'b0;
    drive_idle();
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
    dmem_resp  = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    #12;
    chk("rst_read",     32'(dmem_read),    32'h0);
    chk("rst_write",    32'(dmem_write),   32'h0);
    chk("rst_stall",    32'(mem_stall),    32'h0);
    chk("rst_misalign", 32'(mem_misalign), 32'h0);
    chk("rst_rdata",    mem_rdata,         32'h0);
    chk("rst_mbe",      32'(dmem_mbe),     32'h0);
    chk("rst_state",    32'(dbg_state),    32'h0);
    drive_idle();
    @(negedge clk);
    rst = 1'b1;
    next_cycle();

    // ---- table: single-cycle accesses, response in issue cycle ----
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive_op(v.rd, v.wr, v.f3, v.addr, v.rs2);
      dmem_rdata   = v.rdata;
      dmem_resp    = 1'b1;
      pipe_advance = 1'b1;
      sb_push(v.e_rdata);
      #1;
      chk($sformatf("v%0d_read", i),     32'(dmem_read),    32'(v.e_read));
      chk($sformatf("v%0d_write", i),    32'(dmem_write),   32'(v.e_write));
      chk($sformatf("v%0d_addr", i),     dmem_address,      v.e_addr);
      chk($sformatf("v%0d_wdata", i),    dmem_wdata,        v.e_wdata);
      chk($sformatf("v%0d_mbe", i),      32'(dmem_mbe),     32'(v.e_mbe));
      chk($sformatf("v%0d_misalign", i), 32'(mem_misalign), 32'(v.e_mis));
      chk($sformatf("v%0d_stall", i),    32'(mem_stall),    32'(v.e_stall));
      sb_check($sformatf("v%0d_rdata", i));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_state", i),    32'(dbg_state),    32'h0);
      @(negedge clk);
    end
    drive_idle();
    next_cycle();

    // ---- miss: LBU at 0x203, response after 3 stalled cycles ----
    drive_op(1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'h0);
    dmem_resp    = 1'b0;
    pipe_advance = 1'b0;
    dmem_rdata   = 32'h0;
    sb_push(32'h0000_0080);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("miss_c%0d_stall", c), 32'(mem_stall),  32'h1);
      chk($sformatf("miss_c%0d_read", c),  32'(dmem_read),  32'h1);
      chk($sformatf("miss_c%0d_addr", c),  dmem_address,    32'h0000_0200);
      chk($sformatf("miss_c%0d_mbe", c),   32'(dmem_mbe),   32'hF);
      chk($sformatf("miss_c%0d_state", c), 32'(dbg_state),  (c == 0) ? 32'h0 : 32'h1);
      next_cycle();
    end
    dmem_resp    = 1'b1;
    pipe_advance = 1'b1;
    dmem_rdata   = 32'h80FF_0000;
    #1;
    chk("miss_resp_stall", 32'(mem_stall), 32'h0);
    sb_check("miss_resp_rdata");
    @(posedge clk);
    #1;
    chk("miss_end_state", 32'(dbg_state), 32'h0);
    @(negedge clk);

    // LB at the same address, one wait cycle
    drive_op(1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0);
    dmem_resp    = 1'b0;
    pipe_advance = 1'b0;
    dmem_rdata   = 32'h0;
    sb_push(32'hFFFF_FF80);
    #1;
    chk("lb_wait_stall", 32'(mem_stall), 32'h1);
    next_cycle();
    dmem_resp    = 1'b1;
    pipe_advance = 1'b1;
    dmem_rdata   = 32'h80FF_0000;
    #1;
    chk("lb_resp_stall", 32'(mem_stall), 32'h0);
    sb_check("lb_resp_rdata");
    next_cycle();
    drive_idle();
    next_cycle();

    // ---- downstream hold: LH at 0x10, resp while pipe frozen ----
    drive_op(1'b1, 1'b0, 3'b001, 32'h0000_0010, 32'h0);
    dmem_resp    = 1'b1;
    pipe_advance = 1'b0;
    dmem_rdata   = 32'h0000_8001;
    sb_push(32'hFFFF_8001);
    #1;
    chk("hold_resp_stall", 32'(mem_stall), 32'h0);
    sb_check("hold_resp_rdata");
    next_cycle();
    dmem_resp  = 1'b0;
    dmem_rdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 2; c++) begin
      sb_push(32'hFFFF_8001);
      #1;
      chk($sformatf("hold_c%0d_state", c), 32'(dbg_state), 32'h2);
      chk($sformatf("hold_c%0d_read", c),  32'(dmem_read), 32'h0);
      chk($sformatf("hold_c%0d_stall", c), 32'(mem_stall), 32'h0);
      sb_check($sformatf("hold_c%0d_rdata", c));
      next_cycle();
    end
    pipe_advance = 1'b1;
    sb_push(32'hFFFF_8001);
    #1;
    sb_check("hold_adv_rdata");
    @(posedge clk);
    #1;
    chk("hold_end_state", 32'(dbg_state), 32'h0);
    @(negedge clk);
    drive_idle();
    next_cycle();

    // ---- reset during a miss ----
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
    dmem_resp    = 1'b0;
    pipe_advance = 1'b0;
    next_cycle();
    chk("rmiss_busy_state", 32'(dbg_state), 32'h1);
    chk("rmiss_busy_read",  32'(dmem_read), 32'h1);
    rst = 1'b0;
    #1;
    chk("rmiss_rst_read",  32'(dmem_read), 32'h0);
    chk("rmiss_rst_stall", 32'(mem_stall), 32'h0);
    chk("rmiss_rst_state", 32'(dbg_state), 32'h0);
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    dmem_resp  = 1'b1;
    dmem_rdata = 32'hAAAA_AAAA;
    #1;
    chk("rmiss_late_read", 32'(dmem_read), 32'h0);
    @(posedge clk);
    #1;
    chk("rmiss_late_state", 32'(dbg_state), 32'h0);
    @(negedge clk);
    drive_idle();
    next_cycle();

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
